regfile_write_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file, which commits on the falling clock edge.
- Clears every register after reset, then shares the write port between two writeback requesters: A (ALU writeback) and B (load/memory writeback).
- Uses valid/ready handshakes with round-robin priority on contention.
- Sits between the writeback stage and the register file; drives its regWrite/writeRegister/writeData inputs directly from registered outputs.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_write_arbiter_checker.sv | 23 ++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and shared types for the register-file write arbiter.
//   NUM_REGS / ADDR_W / DATA_W / INIT_VALUE : default register-file geometry
//   arbState_t : arbiter FSM state (INIT clears the file, RUN serves requesters)
//   reqId_t    : requester identity, also used as the round-robin priority value
package regfile_pkg;

  localparam int          NUM_REGS   = 32;
  localparam int          ADDR_W     = 5;
  localparam int          DATA_W     = 32;
  localparam logic [31:0] INIT_VALUE = 32'h0000_0000;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arbState_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } reqId_t;

  // Requester that does not hold priority; it takes priority after losing.
  function automatic reqId_t otherReq(input reqId_t id);
    otherReq = (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_checker.sv
// regfile_write_arbiter_checker: handshake properties of the write arbiter.
//   Inputs only; observes clk/rst, both valid/ready pairs and init_done.
module regfile_write_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic a_valid,
  input logic a_ready,
  input logic b_valid,
  input logic b_ready,
  input logic init_done
);

  // Only one requester may own the write port in a cycle.
  aOneReady: assert property (@(posedge clk) disable iff (rst) !(a_ready && b_ready));

  // A ready never appears without its own request.
  aReadyValid: assert property (@(posedge clk) disable iff (rst) a_ready |-> a_valid);
  bReadyValid: assert property (@(posedge clk) disable iff (rst) b_ready |-> b_valid);

  // Nothing is accepted while the file is still being cleared.
  noGrantInInit: assert property (@(posedge clk) disable iff (rst) !init_done |-> !(a_ready || b_ready));

endmodule

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter with a registered priority bit.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset (priority returns to requester A)
//   valid : {B, A} request pair
//   grant : {B, A} one-hot grant (combinational), all-zero when nothing is valid
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  reqId_t prio_r;
  logic   contention_s;

  assign contention_s = valid[0] & valid[1];

  // Grant selection: a lone requester always wins; on contention priority decides.
  always_comb begin
    grant = 2'b00;
    if (contention_s) begin
      grant = (prio_r == REQ_A) ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

  // Priority register: only contention moves priority, and it moves to the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r <= REQ_A;
    end else if (contention_s) begin
      prio_r <= otherReq(prio_r);
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owner of the register file's single write port.
// After reset it writes INIT_VALUE to every register (x0 included), then
// shares the port between requester A (ALU writeback) and requester B
// (load writeback) with valid/ready handshakes and round-robin priority.
//   clk, rst                    : clock, asynchronous active-high reset
//   a_valid/a_rd/a_data/a_ready : requester A handshake (ready combinational)
//   b_valid/b_rd/b_data/b_ready : requester B handshake (ready combinational)
//   init_done                   : high once every register has been cleared
//   regWrite/writeRegister/writeData : registered register-file write port
module regfile_write_arbiter #(
  parameter int                NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter int                ADDR_W     = regfile_pkg::ADDR_W,
  parameter int                DATA_W     = regfile_pkg::DATA_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(regfile_pkg::INIT_VALUE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              init_done,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

  arbState_t         state_r;
  logic [ADDR_W-1:0] initCnt_r;
  logic              initDone_r;
  logic              regWrite_r;
  logic [ADDR_W-1:0] writeRegister_r;
  logic [DATA_W-1:0] writeData_r;

  logic [1:0]        reqValid_s;
  logic [1:0]        grant_s;

  // Requests are masked during INIT so the arbiter neither grants nor
  // rotates priority until the file has been cleared; requesters hold.
  assign reqValid_s = (state_r == RUN) ? {b_valid, a_valid} : 2'b00;

  rr_arbiter2 uArb (
    .clk   (clk),
    .rst   (rst),
    .valid (reqValid_s),
    .grant (grant_s)
  );

  assign a_ready       = grant_s[0];
  assign b_ready       = grant_s[1];
  assign init_done     = initDone_r;
  assign regWrite      = regWrite_r;
  assign writeRegister = writeRegister_r;
  assign writeData     = writeData_r;

  // Control FSM with the init sweep and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= INIT;
      initCnt_r       <= ZERO_IDX;
      initDone_r      <= 1'b0;
      regWrite_r      <= 1'b0;
      writeRegister_r <= ZERO_IDX;
      writeData_r     <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        INIT: begin
          regWrite_r      <= 1'b1;
          writeRegister_r <= initCnt_r;
          writeData_r     <= INIT_VALUE;
          initCnt_r       <= initCnt_r + ADDR_W'(1);
          if (initCnt_r == LAST_IDX) begin
            state_r    <= RUN;
            initDone_r <= 1'b1;
          end else begin
            state_r    <= INIT;
            initDone_r <= 1'b0;
          end
        end
        RUN: begin
          initDone_r <= 1'b1;
          // x0 writes are accepted (the requester is released) but not enabled.
          if (grant_s[0]) begin
            regWrite_r      <= (a_rd != ZERO_IDX);
            writeRegister_r <= a_rd;
            writeData_r     <= a_data;
          end else if (grant_s[1]) begin
            regWrite_r      <= (b_rd != ZERO_IDX);
            writeRegister_r <= b_rd;
            writeData_r     <= b_data;
          end else begin
            regWrite_r      <= 1'b0;
            writeRegister_r <= writeRegister_r;
            writeData_r     <= writeData_r;
          end
        end
        default: begin
          state_r         <= INIT;
          initCnt_r       <= ZERO_IDX;
          initDone_r      <= 1'b0;
          regWrite_r      <= 1'b0;
          writeRegister_r <= ZERO_IDX;
          writeData_r     <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a small behavioural model
// predicts readies and the next write-port contents; predictions are queued
// when stimulus is applied and compared after the following rising edge.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = 5'd0;
  logic [31:0] a_data = 32'h0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = 5'd0;
  logic [31:0] b_data = 32'h0;
  logic        b_ready;
  logic        init_done;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;

  regfile_write_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .a_valid       (a_valid),
    .a_rd          (a_rd),
    .a_data        (a_data),
    .a_ready       (a_ready),
    .b_valid       (b_valid),
    .b_rd          (b_rd),
    .b_data        (b_data),
    .b_ready       (b_ready),
    .init_done     (init_done),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData)
  );

  regfile_write_arbiter_checker chk (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        done;
  } expWrite_t;

  expWrite_t   sbq[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model state.
  logic        mRun;
  logic        mPrio;   // 0 = A has priority, 1 = B
  int          mCnt;
  logic [4:0]  mWr;
  logic [31:0] mWd;
  logic        mDone;
  logic        lastEa;
  logic        lastEb;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRun  = 1'b0;
    mPrio = 1'b0;
    mCnt  = 0;
    mWr   = 5'd0;
    mWd   = 32'h0;
    mDone = 1'b0;
    sbq.delete();
  endtask

  // One clock cycle: check readies for the current inputs, queue the
  // predicted write port, then compare it after the rising edge.
  task automatic tick();
    expWrite_t e;
    expWrite_t o;
    logic ea;
    logic eb;
    #1;
    ea = mRun && a_valid && (!b_valid || !mPrio);
    eb = mRun && b_valid && (!a_valid || mPrio);
    checkVal("a_ready", {31'd0, a_ready}, {31'd0, ea});
    checkVal("b_ready", {31'd0, b_ready}, {31'd0, eb});
    if (!mRun) begin
      e.we = 1'b1;
      e.wr = mCnt[4:0];
      e.wd = 32'h0;
      if (mCnt == 31) begin
        mRun  = 1'b1;
        mDone = 1'b1;
      end
      mCnt++;
    end else if (ea) begin
      e.we = (a_rd != 5'd0);
      e.wr = a_rd;
      e.wd = a_data;
      if (b_valid) mPrio = 1'b1;
    end else if (eb) begin
      e.we = (b_rd != 5'd0);
      e.wr = b_rd;
      e.wd = b_data;
      if (a_valid) mPrio = 1'b0;
    end else begin
      e.we = 1'b0;
      e.wr = mWr;
      e.wd = mWd;
    end
    e.done = mDone;
    mWr = e.wr;
    mWd = e.wd;
    sbq.push_back(e);
    lastEa = ea;
    lastEb = eb;
    @(posedge clk);
    #1;
    o = sbq.pop_front();
    checkVal("regWrite", {31'd0, regWrite}, {31'd0, o.we});
    checkVal("writeRegister", {27'd0, writeRegister}, {27'd0, o.wr});
    checkVal("writeData", writeData, o.wd);
    checkVal("init_done", {31'd0, init_done}, {31'd0, o.done});
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_regWrite"}, {31'd0, regWrite}, 32'd0);
    checkVal({tag, "_writeRegister"}, {27'd0, writeRegister}, 32'd0);
    checkVal({tag, "_writeData"}, writeData, 32'd0);
    checkVal({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    checkVal({tag, "_a_ready"}, {31'd0, a_ready}, 32'd0);
    checkVal({tag, "_b_ready"}, {31'd0, b_ready}, 32'd0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic rstPulse(input string tag);
    rst = 1'b1;
    #1;
    checkResetOutputs(tag);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [4:0] grantOrder [4];
  logic [4:0] expOrder   [4];
  int         ai;
  int         bi;

  initial begin
    expOrder[0] = 5'd1;
    expOrder[1] = 5'd11;
    expOrder[2] = 5'd2;
    expOrder[3] = 5'd12;
    modelReset();

    // Power-on reset.
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-INIT after 10 clears.
    repeat (10) tick();
    rstPulse("midInit");

    // A requests from reset release; must wait out the full INIT sweep.
    a_valid = 1'b1;
    a_rd    = 5'd7;
    a_data  = 32'h0000_0077;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (lastEa) a_valid = 1'b0;
    end
    checkVal("initReqServed", {31'd0, a_valid}, 32'd0);

    // Lone A write.
    a_valid = 1'b1;
    a_rd    = 5'd5;
    a_data  = 32'hDEAD_BEEF;
    tick();
    a_valid = 1'b0;
    tick();

    // Contention: grants must alternate starting with A.
    ai = 1;
    bi = 11;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_rd   = 5'(ai);
      a_data = 32'hA000_0000 + 32'(ai);
      b_rd   = 5'(bi);
      b_data = 32'hB000_0000 + 32'(bi);
      tick();
      grantOrder[i] = writeRegister;
      if (lastEa) ai++;
      if (lastEb) bi++;
    end
    for (int i = 0; i < 4; i++) begin
      checkVal("grantOrder", {27'd0, grantOrder[i]}, {27'd0, expOrder[i]});
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();

    // x0 write is accepted but not enabled.
    b_valid = 1'b1;
    b_rd    = 5'd0;
    b_data  = 32'h0000_1234;
    tick();
    b_valid = 1'b0;
    tick();

    // Same destination from A then B: both issue in grant order.
    a_valid = 1'b1;
    a_rd    = 5'd9;
    a_data  = 32'h0000_0001;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_rd    = 5'd9;
    b_data  = 32'h0000_0002;
    tick();
    b_valid = 1'b0;
    tick();

    // Reset mid-RUN with a write on the port, then a full new INIT.
    a_valid = 1'b1;
    a_rd    = 5'd3;
    a_data  = 32'h3333_3333;
    tick();
    rstPulse("midRun");
    a_valid = 1'b0;
    repeat (34) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
